// File: rtl/onehot_pattern_tx_if.sv
// Link between a pattern source and the one-hot pattern transmitter.
// The master supplies the request and pattern. The slave (the transmitter)
// returns the serial stream, the predicted detector output and status.
interface onehot_pattern_tx_if #(
  parameter int WIDTH = 8
) ();
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             w;
  logic             w_valid;
  logic             exp_z;
  logic             done;
  logic [2:0]       state;

  modport master (
    output start, pattern, len,
    input  busy, w, w_valid, exp_z, done, state
  );

  modport slave (
    input  start, pattern, len,
    output busy, w, w_valid, exp_z, done, state
  );
endinterface

// File: rtl/onehot_pattern_tx.sv
// Serial stimulus transmitter for the one-hot run detector.
// A captured pattern is shifted out LSB-first on w, one bit per clock.
// exp_z predicts the detector's "two equal consecutive bits" flag, aligned
// cycle for cycle, so the transmitter/detector pair can check itself.
// The control FSM is one-hot and is exported on state for debug.
module onehot_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  onehot_pattern_tx_if.slave    bus
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             w_q;
  logic             w_valid_q;
  logic             prev_w_q;
  logic             prev_v_q;
  logic             exp_z_q;
  logic             done_q;
  logic             busy_q;
  logic             len_ok;

  // A request is accepted only for a length of 1..WIDTH bits
  assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(WIDTH));

  // FSM, shift datapath and detector prediction, all registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      prev_w_q  <= 1'b0;
      prev_v_q  <= 1'b0;
      exp_z_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // The prediction looks at the bit on the wire now and the one before
      // it. w_valid is low in IDLE and DONE, so the history never spans
      // two frames.
      exp_z_q  <= w_valid_q & prev_v_q & (w_q == prev_w_q);
      prev_w_q <= w_q;
      prev_v_q <= w_valid_q;

      case (state_q)
        IDLE: begin
          if (bus.start && len_ok) begin
            // bit 0 goes straight onto the wire; the rest wait in sreg
            w_q       <= bus.pattern[0];
            w_valid_q <= 1'b1;
            sreg_q    <= bus.pattern >> 1;
            len_q     <= bus.len;
            cnt_q     <= LEN_W'(1);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // cnt_q counts the bits already placed on the wire
          if (cnt_q == len_q) begin
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            w_q    <= sreg_q[0];
            sreg_q <= sreg_q >> 1;
            cnt_q  <= cnt_q + LEN_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          w_q       <= 1'b0;
          w_valid_q <= 1'b0;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.w       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.exp_z   = exp_z_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
endmodule
